muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: ADDR_W, default 64, datapath width of operands and result (matches register-file data width).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  request strobe; operands and op sampled when accepted.
REQ-005 i_op  input  2  00 MUL (low ADDR_W bits of unsigned product), 01 DIVU (quotient), 10 REMU (remainder), 11 reserved.
REQ-006 i_rs1_data  input  ADDR_W  operand A / dividend, taken from register-file read_data1.
REQ-007 i_rs2_data  input  ADDR_W  operand B / divisor, taken from register-file read_data2.
REQ-008 i_rd  input  5  destination register index.
REQ-009 o_busy  output  1  high whenever state is not IDLE.
REQ-010 o_done  output  1  one-cycle completion pulse.
REQ-011 o_result  output  ADDR_W  result; valid while o_done is high.
REQ-012 o_rd  output  5  destination index; drives register-file write_reg.
REQ-013 o_we  output  1  write enable = o_done AND (o_rd != 0); drives register-file writedatasignal.

Function
REQ-014 States SHALL be IDLE, MUL, DIV, DONE.
REQ-015 Request SHALL be accepted on a rising edge where i_valid=1 and state=IDLE; i_valid in any other state SHALL be ignored, with no queuing.
REQ-016 On acceptance the block SHALL latch operands, op and rd, clear the iteration counter, and go to MUL (op 00) or DIV (op 01/10).
REQ-017 Op 11 SHALL go directly to DONE with result 0.
REQ-018 MUL SHALL be shift-add, one multiplier bit per cycle, LSB first, with a 2*ADDR_W accumulator; o_result = accumulator[ADDR_W-1:0].
REQ-019 DIV SHALL be restoring division, one quotient bit per cycle, MSB first; remainder register ADDR_W+1 bits wide.
REQ-020 MUL and DIV SHALL each run exactly ADDR_W cycles, then go to DONE; o_done SHALL be high exactly ADDR_W+1 edges after the accepting edge.
REQ-021 Divisor 0: DIV SHALL be skipped; next state DONE; DIVU result all-ones, REMU result = dividend; o_done 1 edge after acceptance.
REQ-022 DONE SHALL last exactly one cycle (o_done=1), then return to IDLE; a new request is accepted no earlier than the edge that leaves DONE+1 cycle (i.e. in IDLE).
REQ-023 o_result and o_rd SHALL hold their last values outside DONE; only o_done/o_we qualify them.
REQ-024 Arithmetic SHALL be unsigned; overflow of MUL beyond ADDR_W bits SHALL be discarded silently.

Reset
REQ-025 i_rst_n low SHALL, asynchronously and at any point including mid-operation, force state=IDLE, counter=0, o_busy=0, o_done=0, o_we=0, o_result=0, o_rd=0, and discard any in-flight operation without producing o_done.
REQ-026 The first request SHALL be accepted no earlier than the first rising edge after i_rst_n deasserts.

Configuration
REQ-027 Macro MULDIV_DIV_EN: when defined, DIVU/REMU behave per REQ-019..REQ-021.
REQ-028 When MULDIV_DIV_EN is undefined, the DIV state and divider datapath SHALL be omitted and ops 01/10 treated as op 11 (result 0, o_done 1 edge after acceptance).

Verification
REQ-029 MUL: A=7, B=6, rd=5 -> o_done at edge 65, o_result=42, o_rd=5, o_we=1.
REQ-030 MUL overflow: A=2^63, B=4, rd=3 -> o_result=0, o_done at edge 65.
REQ-031 DIVU/REMU (MULDIV_DIV_EN): A=100, B=7 -> DIVU 14, REMU 2, each with o_done at edge 65; divisor 0 with A=9 -> DIVU 0xFFFF_FFFF_FFFF_FFFF, REMU 9, with o_done at edge 1.
REQ-032 rd=0: MUL 3x3 -> o_done=1, o_result=9, o_we=0.
REQ-033 Busy drop: i_valid held high with a second request during MUL -> only the first completes; the second is accepted only once IDLE is reached.
REQ-034 Reset mid-MUL at cycle 30 -> o_busy=0 immediately, no o_done; the next request completes normally.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the issuing stage and muldiv_unit.
// master drives the request side, slave (the unit) drives the response side.
interface muldiv_unit_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              i_valid;
    logic [1:0]        i_op;
    logic [ADDR_W-1:0] i_rs1_data;
    logic [ADDR_W-1:0] i_rs2_data;
    logic [4:0]        i_rd;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W-1:0] o_result;
    logic [4:0]        o_rd;
    logic              o_we;

    modport master (
        output i_valid, i_op, i_rs1_data, i_rs2_data, i_rd,
        input  o_busy, o_done, o_result, o_rd, o_we
    );

    modport slave (
        input  i_valid, i_op, i_rs1_data, i_rs2_data, i_rd,
        output o_busy, o_done, o_result, o_rd, o_we
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply (shift-add) and divide (restoring).
// One bit per cycle; MUL/DIV take ADDR_W cycles followed by a single DONE cycle.
// Optional feature macro: MULDIV_DIV_EN enables DIVU/REMU; without it ops 01/10
// complete immediately with result 0, like the reserved op.
module muldiv_unit #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    muldiv_unit_if.slave bus
);

    localparam int unsigned CNT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    state_e state_q, state_d;
    op_e    req_op;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*ADDR_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0]   b_q, b_d;
    logic [4:0]          rd_q, rd_d;
    logic [ADDR_W-1:0]   res_q, res_d;
    logic [4:0]          ord_q, ord_d;
    logic [ADDR_W:0]     mul_sum;
    logic [2*ADDR_W-1:0] mul_step;
    logic                last_step;

`ifdef MULDIV_DIV_EN
    localparam int unsigned REM_W = ADDR_W + 1;
    op_e                 op_q, op_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [ADDR_W-1:0]   quo_q, quo_d;
    logic [ADDR_W+1:0]   div_shift;
    logic                div_ge;
    logic [ADDR_W:0]     rem_step;
    logic [ADDR_W-1:0]   quo_step;
`endif

    assign req_op    = op_e'(bus.i_op);
    assign last_step = (cnt_q == CNT_LAST);

    // One iteration of each algorithm, evaluated from the current registers
    always_comb begin
        // Accumulator upper half gains the multiplicand when the multiplier LSB is set, then shifts right
        mul_sum  = {1'b0, acc_q[2*ADDR_W-1:ADDR_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_step = {mul_sum, acc_q[ADDR_W-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {rem_q, quo_q[ADDR_W-1]};
        div_ge    = (div_shift >= {2'b00, b_q});
        rem_step  = div_ge ? REM_W'(div_shift - {2'b00, b_q}) : div_shift[ADDR_W:0];
        quo_step  = {quo_q[ADDR_W-2:0], div_ge};
`endif
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    case (req_op)
                        OP_MUL:  state_d = S_MUL;
`ifdef MULDIV_DIV_EN
                        OP_DIVU,
                        OP_REMU: state_d = (bus.i_rs2_data == '0) ? S_DONE : S_DIV;
`endif
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_MUL:   if (last_step) state_d = S_DONE;
`ifdef MULDIV_DIV_EN
            S_DIV:   if (last_step) state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs and held result/destination
    always_comb begin
        bus.o_busy   = (state_q != S_IDLE);
        bus.o_done   = (state_q == S_DONE);
        bus.o_we     = (state_q == S_DONE) && (ord_q != '0);
        bus.o_result = res_q;
        bus.o_rd     = ord_q;
    end

    // Datapath next values; result and o_rd only change on the way into DONE
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        b_d   = b_q;
        rd_d  = rd_q;
        res_d = res_q;
        ord_d = ord_q;
`ifdef MULDIV_DIV_EN
        op_d  = op_q;
        rem_d = rem_q;
        quo_d = quo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    cnt_d = '0;
                    acc_d = {{ADDR_W{1'b0}}, bus.i_rs1_data};
                    b_d   = bus.i_rs2_data;
                    rd_d  = bus.i_rd;
`ifdef MULDIV_DIV_EN
                    op_d  = req_op;
                    rem_d = '0;
                    quo_d = bus.i_rs1_data;
`endif
                    case (req_op)
                        OP_MUL: ;
`ifdef MULDIV_DIV_EN
                        OP_DIVU: if (bus.i_rs2_data == '0) begin
                            res_d = '1;
                            ord_d = bus.i_rd;
                        end
                        OP_REMU: if (bus.i_rs2_data == '0) begin
                            res_d = bus.i_rs1_data;
                            ord_d = bus.i_rd;
                        end
`endif
                        default: begin
                            res_d = '0;
                            ord_d = bus.i_rd;
                        end
                    endcase
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = mul_step;
                if (last_step) begin
                    res_d = mul_step[ADDR_W-1:0];
                    ord_d = rd_q;
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                cnt_d = cnt_q + 1'b1;
                rem_d = rem_step;
                quo_d = quo_step;
                if (last_step) begin
                    res_d = (op_q == OP_DIVU) ? quo_step : rem_step[ADDR_W-1:0];
                    ord_d = rd_q;
                end
            end
`endif
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            b_q   <= '0;
            rd_q  <= '0;
            res_q <= '0;
            ord_q <= '0;
`ifdef MULDIV_DIV_EN
            op_q  <= OP_MUL;
            rem_q <= '0;
            quo_q <= '0;
`endif
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            b_q   <= b_d;
            rd_q  <= rd_d;
            res_q <= res_d;
            ord_q <= ord_d;
`ifdef MULDIV_DIV_EN
            op_q  <= op_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (ADDR_W=64) with a latency/result
// model checked every cycle, plus literal expectations per vector.
// Honours MULDIV_DIV_EN the same way as the design.
module tb_muldiv_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cmp_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_unit_if #(.ADDR_W(64)) bus ();

    muldiv_unit #(.ADDR_W(64)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic
    function automatic logic [63:0] model_res(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            2'd0: return a * b;
`ifdef MULDIV_DIV_EN
            2'd1: return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            2'd2: return (b == 64'd0) ? a : a % b;
`endif
            default: return 64'd0;
        endcase
    endfunction

    // Edges from acceptance until the DONE cycle is sampled
    function automatic int model_lat(input logic [1:0] op, input logic [63:0] b);
        if (op == 2'd0) return 65;
`ifdef MULDIV_DIV_EN
        if (op == 2'd1 || op == 2'd2) return (b == 64'd0) ? 1 : 65;
`endif
        return 1;
    endfunction

    int          m_rem = 0;
    logic [63:0] m_pend_res = '0, m_show_res = '0;
    logic [4:0]  m_pend_rd = '0, m_show_rd = '0;

    // Model: accept only when idle, count down the latency, expose result when DONE begins
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0;
            m_show_res = '0;
            m_show_rd = '0;
        end else if (m_rem == 0 && bus.i_valid === 1'b1) begin
            m_pend_res = model_res(bus.i_op, bus.i_rs1_data, bus.i_rs2_data);
            m_pend_rd  = bus.i_rd;
            m_rem      = model_lat(bus.i_op, bus.i_rs2_data);
            if (m_rem == 1) begin
                m_show_res = m_pend_res;
                m_show_rd  = m_pend_rd;
            end
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 1) begin
                m_show_res = m_pend_res;
                m_show_rd  = m_pend_rd;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy",   64'(bus.o_busy),   64'(m_rem > 0));
            chk("cyc_done",   64'(bus.o_done),   64'(m_rem == 1));
            chk("cyc_we",     64'(bus.o_we),     64'((m_rem == 1) && (m_show_rd != 5'd0)));
            chk("cyc_result", bus.o_result,      m_show_res);
            chk("cyc_rd",     64'(bus.o_rd),     64'(m_show_rd));
        end
    end

    task automatic wait_done(output int lat, output logic [63:0] res, output logic [4:0] ordv, output logic we);
        lat = -1; res = '0; ordv = '0; we = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                lat = n; res = bus.o_result; ordv = bus.o_rd; we = bus.o_we;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout actual=none required=o_done within 200 edges");
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          output int lat, output logic [63:0] res, output logic [4:0] ordv, output logic we);
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_op = op; bus.i_rs1_data = a; bus.i_rs2_data = b; bus.i_rd = rd;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        wait_done(lat, res, ordv, we);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    int          lat;
    logic [63:0] res;
    logic [4:0]  ordv;
    logic        we;

    initial begin
        bus.i_valid = 1'b0; bus.i_op = 2'd0; bus.i_rs1_data = '0; bus.i_rs2_data = '0; bus.i_rd = '0;

        vecs.push_back('{2'd0, 64'd7, 64'd6, 5'd5, 64'd42, 65});
        vecs.push_back('{2'd0, 64'h8000_0000_0000_0000, 64'd4, 5'd3, 64'd0, 65});
        vecs.push_back('{2'd0, 64'd3, 64'd3, 5'd0, 64'd9, 65});
        vecs.push_back('{2'd3, 64'd5, 64'd5, 5'd9, 64'd0, 1});
        vecs.push_back('{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 64'd1, 65});
`ifdef MULDIV_DIV_EN
        vecs.push_back('{2'd1, 64'd100, 64'd7, 5'd10, 64'd14, 65});
        vecs.push_back('{2'd2, 64'd100, 64'd7, 5'd11, 64'd2, 65});
        vecs.push_back('{2'd1, 64'd9, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1});
        vecs.push_back('{2'd2, 64'd9, 64'd0, 5'd13, 64'd9, 1});
        vecs.push_back('{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd14, 64'h0FFF_FFFF_FFFF_FFFF, 65});
        vecs.push_back('{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd15, 64'hF, 65});
        vecs.push_back('{2'd1, 64'd5, 64'd9, 5'd16, 64'd0, 65});
        vecs.push_back('{2'd2, 64'd5, 64'd9, 5'd17, 64'd5, 65});
`else
        vecs.push_back('{2'd1, 64'd100, 64'd7, 5'd10, 64'd0, 1});
        vecs.push_back('{2'd2, 64'd100, 64'd7, 5'd11, 64'd0, 1});
        vecs.push_back('{2'd1, 64'd9, 64'd0, 5'd12, 64'd0, 1});
        vecs.push_back('{2'd2, 64'd9, 64'd0, 5'd13, 64'd0, 1});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   64'(bus.o_busy), 64'd0);
        chk("rst_done",   64'(bus.o_done), 64'd0);
        chk("rst_we",     64'(bus.o_we),   64'd0);
        chk("rst_result", bus.o_result,    64'd0);
        chk("rst_rd",     64'(bus.o_rd),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat, res, ordv, we);
            chk($sformatf("v%0d_lat", i),    64'(lat),  64'(vecs[i].lat));
            chk($sformatf("v%0d_result", i), res,       vecs[i].res);
            chk($sformatf("v%0d_rd", i),     64'(ordv), 64'(vecs[i].rd));
            chk($sformatf("v%0d_we", i),     64'(we),   64'(vecs[i].rd != 5'd0));
        end

        // Second request presented with i_valid held high while the first multiplies
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_op = 2'd0; bus.i_rs1_data = 64'd5; bus.i_rs2_data = 64'd5; bus.i_rd = 5'd1;
        @(posedge clk);
        #1 bus.i_rs1_data = 64'd2; bus.i_rs2_data = 64'd8; bus.i_rd = 5'd2;
        wait_done(lat, res, ordv, we);
        chk("bd_first_lat",    64'(lat),  64'd65);
        chk("bd_first_result", res,       64'd25);
        chk("bd_first_rd",     64'(ordv), 64'd1);
        @(posedge clk);
        #1 chk("bd_idle_after_done", 64'(bus.o_busy), 64'd0);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        chk("bd_second_accepted", 64'(bus.o_busy), 64'd1);
        wait_done(lat, res, ordv, we);
        chk("bd_second_lat",    64'(lat),  64'd65);
        chk("bd_second_result", res,       64'd16);
        chk("bd_second_rd",     64'(ordv), 64'd2);

        // Reset 30 cycles into a multiply
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_op = 2'd0; bus.i_rs1_data = 64'd123; bus.i_rs2_data = 64'd456; bus.i_rd = 5'd4;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   64'(bus.o_busy), 64'd0);
        chk("mid_rst_done",   64'(bus.o_done), 64'd0);
        chk("mid_rst_result", bus.o_result,    64'd0);
        chk("mid_rst_rd",     64'(bus.o_rd),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            chk("mid_rst_no_done", 64'(bus.o_done), 64'd0);
        end
        run_op(2'd0, 64'd11, 64'd13, 5'd7, lat, res, ordv, we);
        chk("post_rst_lat",    64'(lat),  64'd65);
        chk("post_rst_result", res,       64'd143);
        chk("post_rst_rd",     64'(ordv), 64'd7);
        chk("post_rst_we",     64'(we),   64'd1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
